// File: rtl/hci_core_source_mo.sv
// TCDM read streamer: strided address generator with credit-limited outstanding reads,
// a response FIFO that is never back-pressured, and byte realignment onto an HWPE stream.
module hci_core_source_mo #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned LEN_WIDTH       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          enable_i,
  input  logic                          start_i,
  input  logic [ADDR_WIDTH-1:0]         base_addr_i,
  input  logic [ADDR_WIDTH-1:0]         stride_i,
  input  logic [LEN_WIDTH-1:0]          len_i,
  output logic                          ready_start_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic                          tcdm_req_o,
  input  logic                          tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0]         tcdm_add_o,
  output logic                          tcdm_wen_o,
  output logic [DATA_WIDTH/8-1:0]       tcdm_be_o,
  input  logic                          tcdm_r_valid_i,
  input  logic [DATA_WIDTH-1:0]         tcdm_r_data_i,
  output logic                          stream_valid_o,
  input  logic                          stream_ready_i,
  output logic [DATA_WIDTH-33:0]        stream_data_o,
  output logic [(DATA_WIDTH-32)/8-1:0]  stream_strb_o
);

  localparam int unsigned OUT_W = DATA_WIDTH - 32;
  localparam int unsigned PW    = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CW    = PW + 1;

  typedef enum logic [1:0] {IDLE, WORKING, DRAIN} state_e;

  function automatic logic [OUT_W-1:0] realign(input logic [DATA_WIDTH-1:0] word,
                                                input logic [1:0] offset);
    return OUT_W'(word >> {offset, 3'b000});
  endfunction

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, stride_q;
  logic [LEN_WIDTH-1:0]    len_q, req_cnt_q, beat_cnt_q;
  logic [CW-1:0]           off_wr_q, dat_wr_q, rd_q;
  logic                    err_q, done_zero_q;
  logic [1:0]              off_mem [MAX_OUTSTANDING];
  logic [DATA_WIDTH-1:0]   dat_mem [MAX_OUTSTANDING];

  logic [CW-1:0] outstanding, reserved;
  logic          has_credit, fifo_empty, grant, rsp_push, rsp_err, pop;
  logic          last_req, last_beat, start_acc, zero_start, done_beat;

  // Offset FIFO is written on grant and data FIFO on response; both share the read pointer,
  // so the pointer differences give in-flight reads and total reserved slots directly.
  assign outstanding = off_wr_q - dat_wr_q;
  assign reserved    = off_wr_q - rd_q;
  assign has_credit  = reserved < CW'(MAX_OUTSTANDING);
  assign fifo_empty  = (dat_wr_q == rd_q);

  assign tcdm_req_o     = enable_i && (state_q == WORKING) && has_credit;
  assign grant          = tcdm_req_o && tcdm_gnt_i;
  assign rsp_push       = tcdm_r_valid_i && (outstanding != '0);
  assign rsp_err        = tcdm_r_valid_i && (outstanding == '0);
  assign stream_valid_o = enable_i && !fifo_empty;
  assign pop            = stream_valid_o && stream_ready_i;
  assign last_req       = (req_cnt_q == len_q - LEN_WIDTH'(1));
  assign last_beat      = (beat_cnt_q == len_q - LEN_WIDTH'(1));

  always_comb begin
    state_d    = state_q;
    start_acc  = 1'b0;
    zero_start = 1'b0;
    done_beat  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i && start_i) begin
          if (len_i != '0) begin
            state_d   = WORKING;
            start_acc = 1'b1;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      WORKING: if (grant && last_req) state_d = DRAIN;
      DRAIN: begin
        if (pop && last_beat) begin
          state_d   = IDLE;
          done_beat = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, accumulator, counters and FIFO pointers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      len_q       <= '0;
      req_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      off_wr_q    <= '0;
      dat_wr_q    <= '0;
      rd_q        <= '0;
      err_q       <= 1'b0;
      done_zero_q <= 1'b0;
    end else if (clear_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      len_q       <= '0;
      req_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      off_wr_q    <= '0;
      dat_wr_q    <= '0;
      rd_q        <= '0;
      err_q       <= 1'b0;
      done_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_zero_q <= zero_start;
      if (rsp_err) err_q <= 1'b1;
      if (start_acc) begin
        addr_q     <= base_addr_i;
        stride_q   <= stride_i;
        len_q      <= len_i;
        req_cnt_q  <= '0;
        beat_cnt_q <= '0;
      end else begin
        if (grant) begin
          addr_q    <= addr_q + stride_q;
          req_cnt_q <= req_cnt_q + LEN_WIDTH'(1);
        end
        if (pop) beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
      end
      if (grant)    off_wr_q <= off_wr_q + CW'(1);
      if (rsp_push) dat_wr_q <= dat_wr_q + CW'(1);
      if (pop)      rd_q     <= rd_q + CW'(1);
    end
  end

  // Storage: slots are only consumed once their pointer advances, so no reset is needed
  always_ff @(posedge clk_i) begin
    if (grant)    off_mem[off_wr_q[PW-1:0]] <= addr_q[1:0];
    if (rsp_push) dat_mem[dat_wr_q[PW-1:0]] <= tcdm_r_data_i;
  end

  assign tcdm_add_o    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign tcdm_wen_o    = 1'b1;
  assign tcdm_be_o     = '0;
  assign stream_data_o = stream_valid_o ? realign(dat_mem[rd_q[PW-1:0]], off_mem[rd_q[PW-1:0]]) : '0;
  assign stream_strb_o = '1;
  assign ready_start_o = (state_q == IDLE);
  assign busy_o        = (state_q == WORKING) || (state_q == DRAIN);
  assign done_o        = done_beat || done_zero_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_hci_core_source_mo.sv
// Scoreboard bench for hci_core_source_mo: a TCDM memory model with programmable grant/latency
// and a stream sink, checking addresses, realigned data, done/err and credit limits.
module tb_hci_core_source_mo;
  localparam int DW = 64, AW = 32, LW = 16, MO = 4, OW = 32;

  logic          clk, rst_ni, clear_i, enable_i, start_i;
  logic [AW-1:0] base_addr_i, stride_i;
  logic [LW-1:0] len_i;
  logic          ready_start_o, busy_o, done_o, err_o;
  logic          tcdm_req_o, tcdm_gnt_i, tcdm_wen_o, tcdm_r_valid_i;
  logic [AW-1:0] tcdm_add_o;
  logic [DW/8-1:0] tcdm_be_o;
  logic [DW-1:0] tcdm_r_data_i;
  logic          stream_valid_o, stream_ready_i;
  logic [OW-1:0] stream_data_o;
  logic [OW/8-1:0] stream_strb_o;

  hci_core_source_mo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .stride_i(stride_i), .len_i(len_i),
    .ready_start_o(ready_start_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_r_valid_i(tcdm_r_valid_i),
    .tcdm_r_data_i(tcdm_r_data_i), .stream_valid_o(stream_valid_o), .stream_ready_i(stream_ready_i),
    .stream_data_o(stream_data_o), .stream_strb_o(stream_strb_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } pend_t;

  pend_t         pend[$];
  logic [AW-1:0] exp_addr[$];
  logic [OW-1:0] exp_data[$];

  int  n_checks = 0, n_errors = 0;
  int  cyc = 0, grants = 0, pops = 0, done_cnt = 0, beats_left = 0, cur_len = 0;
  int  gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;
  bit  inject = 1'b0, stalled = 1'b0;
  logic [OW-1:0] stall_data;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 32'h100) return 64'h1122_3344_5566_7788;
    return {a ^ 32'hDEAD_0000, ~a + 32'h1357};
  endfunction

  function automatic logic [OW-1:0] model_beat(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    w = mem_word({a[AW-1:2], 2'b00});
    return w[8*a[1:0] +: OW];
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive memory/sink inputs at negedge, sample 1ns later
  task automatic step();
    tcdm_gnt_i     = ($urandom_range(99) < gnt_pct);
    stream_ready_i = ($urandom_range(99) < rdy_pct);
    tcdm_r_valid_i = 1'b0;
    tcdm_r_data_i  = '0;
    if (inject) begin
      tcdm_r_valid_i = 1'b1;
      tcdm_r_data_i  = '1;
      inject         = 1'b0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      tcdm_r_valid_i = 1'b1;
      tcdm_r_data_i  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end
    #1;
    if (stalled) begin
      check_eq("stall_valid", stream_valid_o, 1);
      check_eq("stall_data", stream_data_o, stall_data);
    end
    if (!enable_i) check_eq("frozen_req_valid", {tcdm_req_o, stream_valid_o}, 0);
    if (tcdm_req_o && tcdm_gnt_i && !clear_i) begin
      grants++;
      if (exp_addr.size() > 0) check_eq("addr", tcdm_add_o, exp_addr.pop_front());
      else check_eq("extra_grant", grants, cur_len);
      check_eq("inflight_le_max", (grants - pops) <= MO, 1);
      pend.push_back('{addr: tcdm_add_o, due: cyc + int'($urandom_range(lat_max, lat_min))});
    end
    if (stream_valid_o && stream_ready_i && !clear_i) begin
      pops++;
      if (exp_data.size() > 0) check_eq("data", stream_data_o, exp_data.pop_front());
      else check_eq("extra_beat", pops, cur_len);
      beats_left--;
      check_eq("done_on_last", done_o, beats_left == 0);
    end
    if (done_o) done_cnt++;
    stalled    = stream_valid_o && !stream_ready_i && !clear_i && enable_i;
    stall_data = stream_data_o;
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_xfer(input logic [AW-1:0] base, input logic [AW-1:0] stride, input int len);
    logic [AW-1:0] a;
    for (int k = 0; k < len; k++) begin
      a = base + AW'(k) * stride;
      exp_addr.push_back({a[AW-1:2], 2'b00});
      exp_data.push_back(model_beat(a));
    end
    beats_left  = len;
    cur_len     = len;
    grants      = 0;
    pops        = 0;
    base_addr_i = base;
    stride_i    = stride;
    len_i       = LW'(len);
    start_i     = 1'b1;
    step();
    start_i     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, done_cnt != d0, 1);
    check_eq({tag, "_sb_empty"}, exp_data.size(), 0);
    check_eq({tag, "_idle"}, {ready_start_o, busy_o}, 2'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    rst_ni = 1'b0; clear_i = 1'b0; enable_i = 1'b1; start_i = 1'b0;
    base_addr_i = '0; stride_i = '0; len_i = '0;
    tcdm_gnt_i = 1'b0; tcdm_r_valid_i = 1'b0; tcdm_r_data_i = '0; stream_ready_i = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    check_eq("rst_ready_start", ready_start_o, 1);
    check_eq("rst_busy_done_err", {busy_o, done_o, err_o}, 0);
    check_eq("rst_req_valid", {tcdm_req_o, stream_valid_o}, 0);
    check_eq("rst_wen_be", {tcdm_wen_o, tcdm_be_o}, 9'h100);
    check_eq("rst_add_data", {tcdm_add_o, stream_data_o}, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);

    // 1: basic strided transfer, back-to-back grants
    start_xfer(32'h100, 32'h8, 4);
    for (int i = 0; i < 4; i++) step();
    check_eq("t1_consecutive_grants", grants, 4);
    wait_done("t1_done", 50);

    // 2: sink stalled, credits cap in-flight reads at MAX_OUTSTANDING
    rdy_pct = 0;
    start_xfer(32'h200, 32'h4, 8);
    for (int i = 0; i < 10; i++) step();
    check_eq("t2_grants_capped", grants, MO);
    check_eq("t2_req_low", tcdm_req_o, 0);
    rdy_pct = 100;
    wait_done("t2_done", 100);

    // 3: misaligned base, data realigned by 3 bytes
    start_xfer(32'h103, 32'h4, 1);
    wait_done("t3_done", 50);

    // 4: zero-length start
    d0 = done_cnt;
    start_xfer(32'h300, 32'h4, 0);
    check_eq("t4_no_done_same_cycle", done_cnt - d0, 0);
    step();
    check_eq("t4_done_next_cycle", done_cnt - d0, 1);
    step(); step();
    check_eq("t4_single_pulse", done_cnt - d0, 1);
    check_eq("t4_no_grants", grants, 0);
    check_eq("t4_idle", ready_start_o, 1);

    // 5: random grants, latency 1-3, random sink ready
    gnt_pct = 50; lat_min = 1; lat_max = 3; rdy_pct = 70;
    start_xfer(32'h2001, 32'h13, 100);
    wait_done("t5_done", 3000);
    check_eq("t5_no_err", err_o, 0);

    // 7: address arithmetic wraps at 2^ADDR_WIDTH
    gnt_pct = 100; lat_min = 1; lat_max = 1; rdy_pct = 100;
    start_xfer(32'hFFFF_FFF9, 32'h8, 3);
    wait_done("t7_done", 50);

    // 8: enable low freezes requests and stream, responses still land
    lat_min = 2; lat_max = 2;
    start_xfer(32'h500, 32'h4, 6);
    step(); step();
    enable_i = 1'b0;
    for (int i = 0; i < 5; i++) step();
    enable_i = 1'b1;
    wait_done("t8_done", 100);
    check_eq("t8_no_err", err_o, 0);

    // 6: clear mid-transfer, late response flags err, then a clean restart
    lat_min = 3; lat_max = 3; rdy_pct = 0;
    start_xfer(32'h400, 32'h4, 8);
    n = 0;
    while (grants < 3 && n < 50) begin
      step();
      n++;
    end
    check_eq("t6_three_grants", grants, 3);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    pend.delete(); exp_addr.delete(); exp_data.delete();
    stalled = 1'b0; beats_left = 0; cur_len = 0; grants = 0; pops = 0;
    inject = 1'b1;
    step(); step();
    check_eq("t6_err_set", err_o, 1);
    check_eq("t6_idle_outputs", {ready_start_o, busy_o, done_o, tcdm_req_o, stream_valid_o}, 5'b10000);
    rdy_pct = 100; lat_min = 1; lat_max = 1;
    start_xfer(32'h800, 32'h10, 4);
    wait_done("t6_restart_done", 50);
    check_eq("t6_err_sticky", err_o, 1);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    step();
    check_eq("t6_err_cleared", err_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
